// File: rtl/sync_fifo.sv
// Parametrised synchronous FIFO with first-word fall-through read, occupancy,
// programmable almost-full/almost-empty thresholds, flush and sticky error flags.
module sync_fifo #(
  parameter int WIDTH    = 1,
  parameter int DEPTH    = 32,
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 4,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             we,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             re,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             overflow_r;
  logic             underflow_r;

  logic             full_s;
  logic             empty_s;
  logic             push_ok_s;
  logic             pop_ok_s;
  logic [CW-1:0]    count_nxt_s;

  // Explicit wrap keeps non-power-of-two depths inside the array.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1);
    end
  endfunction

  // Status decode and push/pop acceptance, all straight from current count.
  always_comb begin
    full_s    = (count_r == CW'(DEPTH));
    empty_s   = (count_r == {CW{1'b0}});
    push_ok_s = we & ~full_s;
    pop_ok_s  = re & ~empty_s;
  end

  // Occupancy change for this edge.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointer, occupancy and sticky error registers; flush ignores any request.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_r    <= {PW{1'b0}};
      rd_ptr_r    <= {PW{1'b0}};
      count_r     <= {CW{1'b0}};
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      count_r     <= count_nxt_s;
      overflow_r  <= overflow_r | (we & full_s);
      underflow_r <= underflow_r | (re & empty_s);
    end
  end

  // Storage array; contents deliberately survive reset and flush.
  always_ff @(posedge clk) begin
    if (!rst && !flush && push_ok_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Output mapping.
  always_comb begin
    rd_data      = mem_r[rd_ptr_r];
    full         = full_s;
    empty        = empty_s;
    almost_full  = (count_r >= CW'(AF_LEVEL));
    almost_empty = (count_r <= CW'(AE_LEVEL));
    count        = count_r;
    overflow     = overflow_r;
    underflow    = underflow_r;
  end

endmodule
